// File: rtl/regfile_nr1w_if.sv
// Bus bundle between the register file and its users.
//   rs_read  : per-port read request (bit i = port i)
//   rs_addr  : packed read addresses, port i at [i*AW +: AW]
//   rs_rdata : packed registered read data, port i at [i*WIDTH +: WIDTH]
//   rs_valid : per-port flag, high the cycle after a read is accepted
//   rd_write : write enable
//   rd_addr  : write address
//   rd_wdata : write data
// master = decode/writeback side, slave = register file.
interface regfile_nr1w_if #(
    parameter int WIDTH = 32,
    parameter int NREAD = 2,
    parameter int AW    = 4
);
    logic [NREAD-1:0]       rs_read;
    logic [NREAD*AW-1:0]    rs_addr;
    logic [NREAD*WIDTH-1:0] rs_rdata;
    logic [NREAD-1:0]       rs_valid;
    logic                   rd_write;
    logic [AW-1:0]          rd_addr;
    logic [WIDTH-1:0]       rd_wdata;

    modport master (
        output rs_read, rs_addr, rd_write, rd_addr, rd_wdata,
        input  rs_rdata, rs_valid
    );

    modport slave (
        input  rs_read, rs_addr, rd_write, rd_addr, rd_wdata,
        output rs_rdata, rs_valid
    );
endinterface

// File: rtl/regfile_nr1w.sv
// Parametrised register file: one shared storage array, NREAD registered
// read ports with valid flags, one write port.
// Ports:
//   clk          : clock, all state changes on rising edge
//   rst          : synchronous active-high reset, clears storage and outputs
//   vccd1, vssd1 : power pins, no logic function
//   bus          : regfile_nr1w_if slave (read ports + write port)
// Reads have one cycle of latency; idle ports hold their last data.
module regfile_nr1w #(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 16,
    parameter int  NREAD    = 2,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vccd1,
    input  logic          vssd1,
    regfile_nr1w_if.slave bus
);

    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [NREAD*WIDTH-1:0] rdata_q, rdata_d;
    logic [NREAD-1:0]       valid_q, valid_d;
    logic                   wr_ok;

    // Power pins are carried only for top-level hookup.
    logic unused_pwr;
    assign unused_pwr = vccd1 ^ vssd1;

    // A write lands only if in range and not aimed at a hardwired-zero entry.
    always_comb begin
        wr_ok = bus.rd_write
              && ({1'b0, bus.rd_addr} < DEPTH_L)
              && !((ZERO_REG != 0) && (bus.rd_addr == '0));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[bus.rd_addr] = bus.rd_wdata;
        end
    end

    // Read value priority: zero entry, out of range, bypass, stored contents.
    always_comb begin
        rdata_d = rdata_q;
        valid_d = bus.rs_read;
        for (int i = 0; i < NREAD; i++) begin
            if (bus.rs_read[i]) begin
                if ((ZERO_REG != 0) && (bus.rs_addr[i*AW +: AW] == '0)) begin
                    rdata_d[i*WIDTH +: WIDTH] = '0;
                end else if ({1'b0, bus.rs_addr[i*AW +: AW]} >= DEPTH_L) begin
                    rdata_d[i*WIDTH +: WIDTH] = '0;
                end else if ((BYPASS != 0) && wr_ok
                             && (bus.rd_addr == bus.rs_addr[i*AW +: AW])) begin
                    rdata_d[i*WIDTH +: WIDTH] = bus.rd_wdata;
                end else begin
                    rdata_d[i*WIDTH +: WIDTH] = mem_q[bus.rs_addr[i*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            rdata_q <= '0;
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign bus.rs_rdata = rdata_q;
    assign bus.rs_valid = valid_q;

endmodule

// File: doc/regfile_nr1w.md
Name: regfile_nr1w

Overview:
Parametrised register file with NREAD independent read ports and one write port, replacing the fixed 2-read, 16x32 regfile built from duplicated 1R1W lanes. It adds several features the fixed version lacks:
- a single shared storage array
- registered reads with per-port valid flags
- optional same-cycle write-to-read bypass
- optional hardwired-zero entry 0
- synchronous clear on reset

It sits in the core datapath between decode (read addresses) and writeback (write port).

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of 2)
NREAD, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = entry 0 reads as 0 and writes to it are dropped
BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new write data; 0 = returns old contents
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rs_read  in  NREAD  per-port read request; bit i is port i
rs_addr  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
rs_rdata  out  NREAD*WIDTH  registered read data; port i at [i*WIDTH +: WIDTH]
rs_valid  out  NREAD  bit i high the cycle after port i's read is accepted
rd_write  in  1  write enable
rd_addr  in  AW  write address
rd_wdata  in  WIDTH  write data
vccd1  in  1  power pin; no logic function, kept for top-level connection
vssd1  in  1  ground pin; no logic function

Behaviour:
- Reset: the rising edge with rst=1 does all of the following.
  - Clears every storage entry to 0.
  - Sets all rs_rdata to 0 and all rs_valid to 0.
  - Ignores any rd_write or rs_read presented in that same cycle.
- Write: on an edge with rst=0 and rd_write=1, mem[rd_addr] <= rd_wdata. The write is dropped if:
  - rd_addr >= DEPTH, or
  - ZERO_REG=1 and rd_addr=0.
- Read latency is 1 cycle. On an edge with rst=0 and rs_read[i]=1:
  - rs_rdata[i] <= rv(i)
  - rs_valid[i] <= 1
- When rs_read[i]=0 and rst=0:
  - rs_valid[i] <= 0
  - rs_rdata[i] holds its previous value (no toggling on idle ports).
- rv(i) is selected by priority, highest first:
  1. ZERO_REG=1 and rs_addr[i]=0 -> 0
  2. rs_addr[i] >= DEPTH -> 0
  3. BYPASS=1, rd_write=1, rd_addr=rs_addr[i], and the write is not dropped -> rd_wdata
  4. otherwise -> mem[rs_addr[i]] as it was before the edge
- Ports are fully independent:
  - Any number of ports may read the same address in the same cycle, and all receive identical data.
  - There are no port conflicts and no stalls.
- Back-to-back operations:
  - A write at edge N is visible to a read sampled at edge N+1 regardless of BYPASS.
  - With BYPASS=0, a read at edge N of the address written at edge N returns the old value.
- Reset interaction: asserting rst at any time overrides in-flight behaviour. Data captured before the reset is discarded, and rs_valid drops the cycle after.
- No combinational path from any input to any output; all outputs come straight from flops.
- The design must contain no X-sources after the first reset edge.

Test Plan:
1. Reset and clear: write 0xDEADBEEF to entry 5, assert rst for 1 cycle, then read entry 5 on port 0 -> rs_rdata[0]=0x00000000 with rs_valid[0]=1 one cycle after the read; rs_valid=0 during and just after reset.
2. Basic write/read across ports (NREAD=2): write 0x12345678 to entry 3, then next cycle read entry 3 on port 0 and entry 3 on port 1 -> both rs_rdata=0x12345678 with rs_valid=2'b11 one cycle later.
3. Same-cycle bypass: entry 7 holds 0xAAAA0000; in the same cycle write 0x5555FFFF to entry 7 and read entry 7. With BYPASS=1 -> rs_rdata=0x5555FFFF; with BYPASS=0 -> 0xAAAA0000, then 0x5555FFFF on the following read.
4. Zero register: with ZERO_REG=1, write 0xFFFFFFFF to entry 0 and read entry 0 (same cycle and next cycle) -> 0 both times. With ZERO_REG=0, the next-cycle read returns 0xFFFFFFFF.
5. Hold and out-of-range: with DEPTH=12, read entry 4 (value 0x11) then deassert rs_read for 3 cycles -> rs_rdata stays 0x11 and rs_valid=0. Then write 0x22 to entry 13 and read entry 13 -> rs_rdata=0, and all entries 0-11 are unchanged.
6. Reset mid-operation: assert rst in the same cycle as write 0x99 to entry 2 and a read of entry 2 -> entry 2 reads 0 afterwards, and rs_valid stays 0 for the cycle after the reset.
